player_motion_sequencer: RTL
============================

# player_motion_sequencer

Frame-synchronous controller that sequences the player movement datapath. It arbitrates raw left/right key levels into the active-low `moveLeft`/`moveRight` strobes and drives its `pause` input. On collision it freezes the player, then grants a blinking invulnerability window, and it tracks lives down to game-over. It sits between the keyboard decoder / collision detector and the player movement block.

## Interface
Parameters:
- `INITIAL_LIVES`, 3: lives loaded on reset and on `levelStart`; range 1..7.
- `HIT_FRAMES`, 15: frames frozen after a hit; range 1..255.
- `INVULN_FRAMES`, 60: frames of invulnerability after the freeze; range 1..255.
- `BLINK_FRAMES`, 4: frames per visibility half-period while invulnerable; range 1..255.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset; single clock domain.
- `startOfFrame`  in  1  one-cycle pulse per video frame.
- `keyLeft`, `keyRight`  in  1 each  active-high key levels.
- `collision`  in  1  one-cycle pulse when the player hits a hazard.
- `gamePause`  in  1  level, global pause.
- `levelStart`  in  1  one-cycle pulse that starts or restarts play.
- `moveLeft`, `moveRight`  out  1 each  active-low move requests to the movement block.
- `pause`  out  1  freezes the movement block.
- `visible`  out  1  player sprite draw enable.
- `invincible`  out  1  high during RECOVER.
- `lives`  out  3  remaining lives.
- `gameOver`  out  1  high in DEAD.

## Operation
- States: IDLE, ACTIVE, HIT, RECOVER, DEAD. `frameCnt` is an 8-bit down-counter.
- IDLE → ACTIVE on `levelStart`. `lives` loads INITIAL_LIVES on this transition.
- ACTIVE:
  - On `collision` (and `gamePause` low), decrement `lives`.
  - If the new value is 0, go to DEAD. Otherwise go to HIT and load `frameCnt` with HIT_FRAMES.
- HIT: `pause` is 1. Decrement `frameCnt` on each `startOfFrame`. When it is 1 at a `startOfFrame`, go to RECOVER and load INVULN_FRAMES.
- RECOVER:
  - Movement is allowed and `collision` is ignored.
  - `frameCnt` counts down the same way as in HIT; on expiry go to ACTIVE.
  - `visible` toggles every BLINK_FRAMES frames via an 8-bit blink counter, starting at 1 on entry.
- DEAD: `pause`=1, `gameOver`=1. Only `levelStart` leaves this state; it goes to ACTIVE with lives reloaded.
- `levelStart` in any state forces ACTIVE, reloads lives, and clears the counters. It has priority over `collision`.
- Key arbitration (ACTIVE/RECOVER only):
  - One key pressed: that direction is requested.
  - Both pressed: the most recently pressed key wins. A 1-bit `lastKey` register is updated on each rising edge of either key.
  - If both keys rise in the same cycle, right wins.
  - No key pressed: no move.
- In IDLE, HIT, and DEAD, `moveLeft` = `moveRight` = 1, meaning no move.
- `pause` = `gamePause` OR (state ∈ {IDLE, HIT, DEAD}).
- `gamePause` high freezes `frameCnt`, the blink counter, and collision handling. State is held.
- `lives` saturates at 0 and never wraps.

## Timing
- All outputs are registered: one-cycle latency from any input to its output.
- Reset values:
  - state=IDLE, lives=INITIAL_LIVES, frameCnt=0.
  - moveLeft=1, moveRight=1, pause=1.
  - visible=1, invincible=0, gameOver=0.
- Key edges are detected against a 1-cycle delayed copy, so a key registers 1 cycle after it rises.
- A `collision` and `startOfFrame` in the same cycle in ACTIVE: the collision is taken, and the counter loads rather than decrements.
- Reset asserted mid-HIT/RECOVER returns to reset values on the next edge with no residual count.

## Structure
- Shared package `player_pkg`:
  - `typedef enum logic [2:0] player_state_t` with IDLE, ACTIVE, HIT, RECOVER, DEAD.
  - `LIVES_W`=3 and `FRAME_CNT_W`=8.
- One natural sub-module: `key_arbiter`. It holds the key edge detect and `lastKey`, takes `keyLeft`/`keyRight` plus an enable, and outputs active-low `moveLeft`/`moveRight`.

## Test plan
- Reset, then `levelStart`:
  - After reset: pause=1, lives=3, moveLeft/moveRight=1.
  - One cycle after `levelStart`: state ACTIVE, pause=0.
- ACTIVE, keyLeft=1 → moveLeft=0 after 2 cycles. Then add keyRight=1 → moveRight=0, moveLeft=1. Release right → moveLeft=0.
- `collision` with lives=3:
  - Next cycle: lives=2, pause=1.
  - After 15 `startOfFrame` pulses: invincible=1, pause=0, `visible` toggles every 4 frames.
  - After 60 frames: ACTIVE, visible=1.
- `collision` during RECOVER → lives unchanged. Collision with lives=1 → lives=0, gameOver=1, pause=1; keys are ignored.
- `gamePause`=1 for 20 frames mid-HIT → frameCnt held; HIT still lasts exactly 15 unpaused frames.
- `levelStart` and `collision` in the same cycle in ACTIVE → ACTIVE, lives=3. Reset asserted mid-RECOVER → all reset values next cycle.

Source files
------------

// File: rtl/player_pkg.sv
// rtl/player_pkg.sv - shared state type, widths and helpers for the player motion sequencer
package player_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACTIVE  = 3'd1,
    HIT     = 3'd2,
    RECOVER = 3'd3,
    DEAD    = 3'd4
  } player_state_t;

  localparam int LIVES_W     = 3;
  localparam int FRAME_CNT_W = 8;

  // States in which the movement block must be frozen regardless of gamePause.
  function automatic logic state_freezes(input player_state_t s);
    return (s == IDLE) || (s == HIT) || (s == DEAD);
  endfunction

  function automatic logic state_moves(input player_state_t s);
    return (s == ACTIVE) || (s == RECOVER);
  endfunction

endpackage

// File: rtl/key_arbiter.sv
// rtl/key_arbiter.sv - key edge detect and last-pressed-wins arbitration into active-low move strobes
module key_arbiter (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic keyLeft,
  input  logic keyRight,
  output logic moveLeft,
  output logic moveRight
);

  logic r_left_d;
  logic r_right_d;
  logic r_last_right;
  logic w_rise_left;
  logic w_rise_right;
  logic w_want_left;
  logic w_want_right;

  assign w_rise_left  = keyLeft  & ~r_left_d;
  assign w_rise_right = keyRight & ~r_right_d;

  // Arbitrate on the delayed levels so a key takes effect one cycle after its edge is seen.
  assign w_want_left  = r_left_d  & (~r_right_d | ~r_last_right);
  assign w_want_right = r_right_d & (~r_left_d  |  r_last_right);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_left_d     <= 1'b0;
      r_right_d    <= 1'b0;
      r_last_right <= 1'b0;
      moveLeft     <= 1'b1;
      moveRight    <= 1'b1;
    end else begin
      r_left_d  <= keyLeft;
      r_right_d <= keyRight;
      if (w_rise_right) begin
        r_last_right <= 1'b1;
      end else if (w_rise_left) begin
        r_last_right <= 1'b0;
      end
      moveLeft  <= ~(enable & w_want_left);
      moveRight <= ~(enable & w_want_right);
    end
  end

endmodule

// File: rtl/player_motion_sequencer.sv
// rtl/player_motion_sequencer.sv - frame-synchronous hit/recover/lives sequencer driving the player movement block
module player_motion_sequencer
  import player_pkg::*;
#(
  parameter int INITIAL_LIVES = 3,
  parameter int HIT_FRAMES    = 15,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_FRAMES  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               keyLeft,
  input  logic               keyRight,
  input  logic               collision,
  input  logic               gamePause,
  input  logic               levelStart,
  output logic               moveLeft,
  output logic               moveRight,
  output logic               pause,
  output logic               visible,
  output logic               invincible,
  output logic [LIVES_W-1:0] lives,
  output logic               gameOver
);

  player_state_t          r_state;
  player_state_t          w_state_nxt;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic [FRAME_CNT_W-1:0] r_blink_cnt;
  logic                   w_tick;
  logic                   w_hit;
  logic                   w_cnt_last;
  logic [LIVES_W-1:0]     w_lives_dec;

  assign w_tick      = startOfFrame & ~gamePause;
  assign w_hit       = collision & ~gamePause;
  assign w_cnt_last  = (r_frame_cnt <= FRAME_CNT_W'(1));
  assign w_lives_dec = (lives == '0) ? '0 : lives - 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    if (levelStart) begin
      w_state_nxt = ACTIVE;
    end else begin
      case (r_state)
        ACTIVE:  if (w_hit) w_state_nxt = (w_lives_dec == '0) ? DEAD : HIT;
        HIT:     if (w_tick && w_cnt_last) w_state_nxt = RECOVER;
        RECOVER: if (w_tick && w_cnt_last) w_state_nxt = ACTIVE;
        IDLE, DEAD: w_state_nxt = r_state;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Outputs follow the next state so every output lands one cycle after its cause.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_frame_cnt <= '0;
      r_blink_cnt <= '0;
      lives       <= LIVES_W'(INITIAL_LIVES);
      pause       <= 1'b1;
      visible     <= 1'b1;
      invincible  <= 1'b0;
      gameOver    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      pause      <= gamePause | state_freezes(w_state_nxt);
      invincible <= (w_state_nxt == RECOVER);
      gameOver   <= (w_state_nxt == DEAD);
      if (levelStart) begin
        lives       <= LIVES_W'(INITIAL_LIVES);
        r_frame_cnt <= '0;
        r_blink_cnt <= '0;
        visible     <= 1'b1;
      end else begin
        case (r_state)
          ACTIVE: begin
            if (w_hit) begin
              lives       <= w_lives_dec;
              r_frame_cnt <= FRAME_CNT_W'(HIT_FRAMES);
            end
          end
          HIT: begin
            if (w_tick && w_cnt_last) begin
              r_frame_cnt <= FRAME_CNT_W'(INVULN_FRAMES);
              r_blink_cnt <= FRAME_CNT_W'(BLINK_FRAMES);
              visible     <= 1'b1;
            end else if (w_tick) begin
              r_frame_cnt <= r_frame_cnt - 1'b1;
            end
          end
          RECOVER: begin
            if (w_tick && w_cnt_last) begin
              r_frame_cnt <= '0;
              r_blink_cnt <= '0;
              visible     <= 1'b1;
            end else if (w_tick) begin
              r_frame_cnt <= r_frame_cnt - 1'b1;
              if (r_blink_cnt <= FRAME_CNT_W'(1)) begin
                r_blink_cnt <= FRAME_CNT_W'(BLINK_FRAMES);
                visible     <= ~visible;
              end else begin
                r_blink_cnt <= r_blink_cnt - 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  key_arbiter u_key_arbiter (
    .clk       (clk),
    .reset     (reset),
    .enable    (state_moves(w_state_nxt)),
    .keyLeft   (keyLeft),
    .keyRight  (keyRight),
    .moveLeft  (moveLeft),
    .moveRight (moveRight)
  );

endmodule
